conv_window_ctrl: RTL and testbench
===================================

Name: conv_window_ctrl

Overview:
Sequencer for the 3x3 sliding-window line buffer. It drives the buffer's write strobe `fire` during row loads and its window-issue strobe `done`, which is pulsed TI times per window position, once per channel slice. It walks the output raster (INPUT_SIZE-2)x(INPUT_SIZE-2), handshaking with the upstream pixel source and the downstream PE array. It sits between the input DMA/stream and the line buffer, alongside the MAC array.

Parameters:
TI, 3, channels packed per buffer word (slices issued per window)
INPUT_SIZE, 16, feature-map width/height in pixels
INPUT_CHANNEL, 3, total input channels; ITER = INPUT_CHANNEL/TI (integer, >=1)
CNT_BITS, 9, width of row/column counters

Ports:
clk  in  1  clock, all state changes on rising edge
rst_n  in  1  reset; asynchronous, active-low
start  in  1  begin one frame; sampled only in IDLE
in_valid  in  1  upstream word available
in_ready  out  1  controller accepting words (state LOAD or ROWLD)
fire  out  1  buffer write strobe = in_valid & in_ready (combinational)
pe_ready  in  1  PE array can accept a window slice this cycle
done  out  1  window-slice issue strobe = (state==COMP) & pe_ready (combinational)
slice_idx  out  5  current slice 0..TI-1, valid while done=1
out_col  out  CNT_BITS  output column 0..INPUT_SIZE-3
out_row  out  CNT_BITS  output row 0..INPUT_SIZE-3
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all counters 0; in_ready=0, fire=0, done=0, busy=0, frame_done=0, slice_idx=0, out_col=0, out_row=0. Reset mid-frame aborts immediately with no completion pulse.
- States: IDLE, LOAD, COMP, ROWLD, FIN.
- IDLE: start=1 -> LOAD and clear all counters. Otherwise hold. start is ignored in every other state.
- LOAD (preload 3 rows): target is 3*ITER*INPUT_SIZE fires. load_cnt increments on each fire. A fire with load_cnt==target-1 -> COMP and load_cnt cleared. in_valid=0 simply stalls; there is no timeout.
- COMP: done asserts in any cycle where pe_ready=1. On each done:
  - slice_idx increments.
  - At slice_idx==TI-1: slice_idx wraps to 0 and out_col increments.
  - At end of row (slice_idx==TI-1 and out_col==INPUT_SIZE-3): out_col wraps to 0, then:
    - out_row==INPUT_SIZE-3 -> FIN
    - otherwise -> ROWLD, with out_row incremented.
  - pe_ready=0 freezes all counters with done=0. A slice is never skipped or duplicated.
- ROWLD: target is ITER*INPUT_SIZE fires, with the same counting rules as LOAD. Completion -> COMP.
- FIN: frame_done=1 for exactly one cycle, then -> IDLE. busy drops in the IDLE cycle.
- Throughput: one slice per cycle with pe_ready held high. First done occurs the cycle after the final preload fire.
- Counter widths are unsigned. Wrap and end conditions use equality compares only, with no overflow past the limits.
- fire and done are never high in the same cycle.

Optional Feature:
CONV_CTRL_STALL_STATS_EN
- Defined: adds output port stall_cnt [15:0]. It counts cycles in COMP with pe_ready=0 plus cycles in LOAD/ROWLD with in_valid=0. It saturates at 16'hFFFF, clears on accepted start, and resets to 0.
- Undefined: the port and its counter are absent; behaviour is otherwise identical.

Test Plan:
1. Defaults (TI=3, INPUT_SIZE=16, ITER=1); pulse start with in_valid and pe_ready held 1 -> 48 fires in LOAD, then 42 consecutive done pulses (slice_idx 0,1,2 repeating, out_col 0..13), then 16 fires. The frame totals 256 fires and 588 dones, and frame_done is a single pulse after the last done with out_row=13, out_col=13, slice_idx=2.
2. Toggle pe_ready every other cycle in COMP -> done appears only on pe_ready=1 cycles. The slice/column sequence is identical to test 1, and the total done count stays 588.
3. Drop in_valid for 5 cycles mid-LOAD at load_cnt=20 -> in_ready stays 1 and fire=0 for those cycles. The transition to COMP occurs exactly on the 48th fire.
4. Assert start while busy (during COMP) -> no effect; counters continue. A start in the cycle after frame_done begins a new frame with load_cnt=0.
5. Deassert rst_n during ROWLD at out_row=5 -> all outputs go to 0 asynchronously. After release with no start, the block stays in IDLE with busy=0.
6. With CONV_CTRL_STALL_STATS_EN defined, run test 2 -> stall_cnt equals the number of pe_ready=0 cycles in COMP. With the macro undefined, the design compiles without the port.

Source files
------------

// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: 3x3 line-buffer sequencer (row preload, per-slice window issue, raster walk).
// Optional CONV_CTRL_STALL_STATS_EN adds a saturating stall_cnt output.
module conv_window_ctrl #(
  parameter int TI            = 3,
  parameter int INPUT_SIZE    = 16,
  parameter int INPUT_CHANNEL = 3,
  parameter int CNT_BITS      = 9
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                fire,
  input  logic                pe_ready,
  output logic                done,
  output logic [4:0]          slice_idx,
  output logic [CNT_BITS-1:0] out_col,
  output logic [CNT_BITS-1:0] out_row,
  output logic                busy,
  output logic                frame_done
`ifdef CONV_CTRL_STALL_STATS_EN
  ,
  output logic [15:0]         stall_cnt
`endif
);
  localparam int ITER   = INPUT_CHANNEL / TI;
  localparam int LOAD_N = 3 * ITER * INPUT_SIZE;
  localparam int ROW_N  = ITER * INPUT_SIZE;
  localparam int LW     = $clog2(LOAD_N + 1);
  typedef enum logic [2:0] {IDLE, LOAD, COMP, ROWLD, FIN} state_t;
  state_t              r_state;
  logic [LW-1:0]       r_load_cnt;
  logic [4:0]          r_slice;
  logic [CNT_BITS-1:0] r_col;
  logic [CNT_BITS-1:0] r_row;
  logic                w_load_last;
  logic                w_slice_last;
  logic                w_col_last;
  logic                w_row_last;
  assign in_ready     = (r_state == LOAD) || (r_state == ROWLD);
  assign fire         = in_valid && in_ready;
  assign done         = (r_state == COMP) && pe_ready;
  assign busy         = r_state != IDLE;
  assign frame_done   = r_state == FIN;
  assign slice_idx    = r_slice;
  assign out_col      = r_col;
  assign out_row      = r_row;
  assign w_load_last  = r_load_cnt == ((r_state == LOAD) ? LW'(LOAD_N - 1) : LW'(ROW_N - 1));
  assign w_slice_last = r_slice == 5'(TI - 1);
  assign w_col_last   = r_col == CNT_BITS'(INPUT_SIZE - 3);
  assign w_row_last   = r_row == CNT_BITS'(INPUT_SIZE - 3);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_load_cnt <= '0;
      r_slice    <= '0;
      r_col      <= '0;
      r_row      <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_state    <= LOAD;
          r_load_cnt <= '0;
          r_slice    <= '0;
          r_col      <= '0;
          r_row      <= '0;
        end
        LOAD, ROWLD: if (fire) begin
          r_load_cnt <= w_load_last ? '0 : r_load_cnt + 1'b1;
          if (w_load_last) r_state <= COMP;
        end
        // Window issue: slice fastest, then column, then row.
        COMP: if (pe_ready) begin
          r_slice <= w_slice_last ? '0 : r_slice + 1'b1;
          if (w_slice_last) begin
            r_col <= w_col_last ? '0 : r_col + 1'b1;
            if (w_col_last) begin
              r_state <= w_row_last ? FIN : ROWLD;
              if (!w_row_last) r_row <= r_row + 1'b1;
            end
          end
        end
        FIN:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
`ifdef CONV_CTRL_STALL_STATS_EN
  logic [15:0] r_stall;
  logic        w_stall;
  assign w_stall   = ((r_state == COMP) && !pe_ready) || (in_ready && !in_valid);
  assign stall_cnt = r_stall;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_stall <= '0;
    else if (r_state == IDLE && start) r_stall <= '0;
    else if (w_stall && r_stall != 16'hFFFF) r_stall <= r_stall + 16'd1;
  end
`endif
endmodule

// File: tb/tb_conv_window_ctrl.sv
// tb_conv_window_ctrl: directed bench for conv_window_ctrl at default parameters
// (16x16 map, TI=3, ITER=1: 48 preload fires, 14x14 windows, 3 slices each).
module tb_conv_window_ctrl;
  logic       clk = 0;
  logic       rst_n, start, in_valid, pe_ready;
  logic       in_ready, fire, done, busy, frame_done;
  logic [4:0] slice_idx;
  logic [8:0] out_col, out_row;
`ifdef CONV_CTRL_STALL_STATS_EN
  logic [15:0] stall_cnt;
`endif
  int total = 0, bad = 0;
  int m_st = 0, m_ld = 0, m_k = 0, m_stall = 0;
  int n_fire, n_done, n_fd, comp_stall, first_comp_fires;

  conv_window_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .fire(fire), .pe_ready(pe_ready), .done(done), .slice_idx(slice_idx), .out_col(out_col),
    .out_row(out_row), .busy(busy), .frame_done(frame_done)
`ifdef CONV_CTRL_STALL_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // One clock: check outputs against the event-count model, then advance it.
  task automatic cyc();
    logic e_ir, e_fire, e_done;
    #1;
    e_ir   = (m_st == 1) || (m_st == 3);
    e_fire = in_valid && e_ir;
    e_done = (m_st == 2) && pe_ready;
    total += 5;
    if (in_ready !== e_ir) begin bad++; $display("FAIL in_ready t=%0t got=%b exp=%b", $time, in_ready, e_ir); end
    if (fire !== e_fire) begin bad++; $display("FAIL fire t=%0t got=%b exp=%b", $time, fire, e_fire); end
    if (done !== e_done) begin bad++; $display("FAIL done t=%0t got=%b exp=%b", $time, done, e_done); end
    if (busy !== (m_st != 0)) begin bad++; $display("FAIL busy t=%0t got=%b exp=%b", $time, busy, m_st != 0); end
    if (frame_done !== (m_st == 4)) begin bad++; $display("FAIL frame_done t=%0t got=%b exp=%b", $time, frame_done, m_st == 4); end
    if (e_done) begin
      total += 3;
      if (slice_idx !== 5'(m_k % 3)) begin bad++; $display("FAIL slice_idx k=%0d got=%0d exp=%0d", m_k, slice_idx, m_k % 3); end
      if (out_col !== 9'((m_k / 3) % 14)) begin bad++; $display("FAIL out_col k=%0d got=%0d exp=%0d", m_k, out_col, (m_k / 3) % 14); end
      if (out_row !== 9'(m_k / 42)) begin bad++; $display("FAIL out_row k=%0d got=%0d exp=%0d", m_k, out_row, m_k / 42); end
    end
`ifdef CONV_CTRL_STALL_STATS_EN
    total++;
    if (stall_cnt !== 16'(m_stall)) begin bad++; $display("FAIL stall_cnt t=%0t got=%0d exp=%0d", $time, stall_cnt, m_stall); end
`endif
    if (fire === 1'b1) n_fire++;
    if (done === 1'b1) n_done++;
    if (frame_done === 1'b1) n_fd++;
    if (first_comp_fires < 0 && m_st == 2) first_comp_fires = n_fire;
    if (m_st == 2 && !pe_ready) comp_stall++;
    if (((m_st == 2) && !pe_ready) || (e_ir && !in_valid)) m_stall = (m_stall < 65535) ? m_stall + 1 : m_stall;
    case (m_st)
      0: if (start) begin m_st = 1; m_ld = 0; m_k = 0; m_stall = 0; end
      1, 3: if (e_fire) begin
        m_ld++;
        if (m_ld == ((m_st == 1) ? 48 : 16)) begin m_st = 2; m_ld = 0; end
      end
      2: if (pe_ready) begin
        m_k++;
        if (m_k % 42 == 0) m_st = (m_k == 588) ? 4 : 3;
      end
      default: m_st = 0;
    endcase
    @(negedge clk);
  endtask

  // mode 0: all ready; 1: pe_ready toggles; 2: in_valid gap at load 20; 3: start mid-COMP
  task automatic run_frame(input int mode, input int abort_row, output logic aborted);
    int guard = 0, drop = 0;
    logic dropped = 0, tog = 0;
    n_fire = 0; n_done = 0; n_fd = 0; comp_stall = 0; first_comp_fires = -1; aborted = 0;
    start = 1; in_valid = 1; pe_ready = 1;
    cyc();
    start = 0;
    while (m_st != 0 && guard < 5000) begin
      if (abort_row >= 0 && m_st == 3 && m_k == abort_row * 42 && m_ld == 3) begin aborted = 1; return; end
      if (mode == 2 && !dropped && m_st == 1 && m_ld == 20) begin drop = 5; dropped = 1; end
      in_valid = (drop == 0);
      if (drop > 0) drop--;
      tog = !tog;
      pe_ready = (mode == 1) ? tog : 1'b1;
      start = (mode == 3 && m_st == 2 && m_k == 100);
      cyc();
      start = 0;
      guard++;
    end
    total++;
    if (m_st != 0) begin bad++; $display("FAIL frame_timeout cycles=%0d required<5000", guard); end
    in_valid = 0; pe_ready = 0;
  endtask

  task automatic check_totals(input string tag);
    total += 3;
    if (n_fire != 256) begin bad++; $display("FAIL %s_fires got=%0d exp=256", tag, n_fire); end
    if (n_done != 588) begin bad++; $display("FAIL %s_dones got=%0d exp=588", tag, n_done); end
    if (n_fd != 1) begin bad++; $display("FAIL %s_frame_done_pulses got=%0d exp=1", tag, n_fd); end
  endtask

  task automatic check_all_zero(input string tag);
    total++;
    if ({in_ready, fire, done, busy, frame_done, slice_idx, out_col, out_row} !== '0)
      begin bad++; $display("FAIL %s got ir=%b f=%b d=%b b=%b fd=%b s=%0d c=%0d r=%0d exp all 0", tag,
        in_ready, fire, done, busy, frame_done, slice_idx, out_col, out_row); end
  endtask

  task automatic test_reset();
    rst_n = 0; start = 0; in_valid = 1; pe_ready = 1;
    @(negedge clk);
    check_all_zero("reset_outputs");
    @(negedge clk);
    rst_n = 1;
    repeat (3) cyc();
  endtask

  task automatic test_full_frame();
    logic ab;
    run_frame(0, -1, ab);
    check_totals("full");
    total++;
    if (first_comp_fires != 48) begin bad++; $display("FAIL full_preload got=%0d exp=48", first_comp_fires); end
  endtask

  task automatic test_pe_toggle();
    logic ab;
    run_frame(1, -1, ab);
    check_totals("toggle");
`ifdef CONV_CTRL_STALL_STATS_EN
    total++;
    if (stall_cnt !== 16'(comp_stall)) begin bad++; $display("FAIL toggle_stall got=%0d exp=%0d", stall_cnt, comp_stall); end
`endif
  endtask

  task automatic test_in_valid_gap();
    logic ab;
    run_frame(2, -1, ab);
    check_totals("gap");
    total++;
    if (first_comp_fires != 48) begin bad++; $display("FAIL gap_preload got=%0d exp=48", first_comp_fires); end
  endtask

  task automatic test_back_to_back();
    logic ab;
    run_frame(3, -1, ab);
    check_totals("busy_start");
    run_frame(0, -1, ab);
    check_totals("back_to_back");
    total++;
    if (first_comp_fires != 48) begin bad++; $display("FAIL b2b_preload got=%0d exp=48", first_comp_fires); end
  endtask

  task automatic test_async_reset();
    logic ab;
    run_frame(0, 5, ab);
    total += 2;
    if (ab !== 1'b1) begin bad++; $display("FAIL abort_reach got=%b exp=1", ab); end
    if (out_row !== 9'd5) begin bad++; $display("FAIL abort_row got=%0d exp=5", out_row); end
    in_valid = 1; pe_ready = 1;
    #2 rst_n = 0;
    #1 check_all_zero("async_reset");
    m_st = 0; m_ld = 0; m_k = 0; m_stall = 0;
    @(negedge clk);
    rst_n = 1;
    repeat (6) cyc();
    check_all_zero("post_reset_idle");
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_pe_toggle();
    test_in_valid_gap();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
